// File: rtl/game_pkg.sv
// Shared state encoding and default sizing for the game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam int MAX_MISS_DEF       = 7;
  localparam int COMBO_W_DEF        = 8;
  localparam int RESULT_TIMEOUT_DEF = 0;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a level key; registered copy resets high so a key
// held through reset release is not seen as a press. Zero-latency combinational rise.
module key_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic rise
);

  logic r_key_q;

  always_ff @(posedge clk) begin
    if (!resetn) r_key_q <= 1'b1;
    else         r_key_q <= key;
  end

  assign rise = key & ~r_key_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game screen flow FSM (IDLE/PLAY/PAUSE/WIN/LOSE) with miss and combo counters;
// outputs are Moore, one cycle after the trigger. Macro GAME_PAUSE_EN adds the PAUSE screen.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter  int MAX_MISS       = MAX_MISS_DEF,
  parameter  int COMBO_W        = COMBO_W_DEF,
  parameter  int RESULT_TIMEOUT = RESULT_TIMEOUT_DEF,
  localparam int MISS_W         = $clog2(MAX_MISS + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_start,
  input  logic               key_back,
  input  logic               miss,
  input  logic               hit,
  input  logic               done,
  output logic               menu,
  output logic               map,
  output logic               paused,
  output logic               win,
  output logic               lose,
  output logic [MISS_W-1:0]  total_miss,
  output logic [COMBO_W-1:0] combo
);

  localparam int              TO_W    = $clog2(RESULT_TIMEOUT + 2);
  localparam bit              TO_EN   = (RESULT_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? RESULT_TIMEOUT - 1 : 0);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MISS_W-1:0]   r_total_miss;
  logic [COMBO_W-1:0]  r_combo;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_start_rise;
  logic                w_back_rise;
  logic                w_timeout;
  logic                w_result;

  key_edge_detect u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .key    (key_start),
    .rise   (w_start_rise)
  );

  key_edge_detect u_back_edge (
    .clk    (clk),
    .resetn (resetn),
    .key    (key_back),
    .rise   (w_back_rise)
  );

  assign w_result  = (r_state == ST_WIN) || (r_state == ST_LOSE);
  assign w_timeout = TO_EN && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A simultaneous back press always wins over start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_rise && !w_back_rise) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (w_back_rise) begin
`ifdef GAME_PAUSE_EN
          w_state_nxt = ST_PAUSE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else if (done) begin
          w_state_nxt = ST_WIN;
        end else if (miss && (r_total_miss == MISS_LAST)) begin
          w_state_nxt = ST_LOSE;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (w_back_rise)       w_state_nxt = ST_IDLE;
        else if (w_start_rise) w_state_nxt = ST_PLAY;
      end
`endif
      ST_WIN, ST_LOSE: if (w_back_rise || w_timeout) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    menu   = 1'b0;
    map    = 1'b0;
    paused = 1'b0;
    win    = 1'b0;
    lose   = 1'b0;
    if (!resetn) begin
      menu = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: menu = 1'b1;
        ST_PLAY: map  = 1'b1;
`ifdef GAME_PAUSE_EN
        ST_PAUSE: begin
          map    = 1'b1;
          paused = 1'b1;
        end
`endif
        ST_WIN:  win  = 1'b1;
        ST_LOSE: lose = 1'b1;
        default: menu = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_total_miss <= '0;
      r_combo      <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_state_nxt == ST_PLAY) begin
        r_total_miss <= '0;
        r_combo      <= '0;
      end
    end else if ((r_state == ST_PLAY) && !w_back_rise && !done) begin
      if (miss) begin
        r_total_miss <= r_total_miss + 1'b1;
        r_combo      <= '0;
      end else if (hit && (r_combo != '1)) begin
        r_combo <= r_combo + 1'b1;
      end
    end
  end

  // Any state change restarts the result-screen timer, so each WIN/LOSE entry starts at 0.
  always_ff @(posedge clk) begin
    if (!resetn)                       r_to_cnt <= '0;
    else if (w_state_nxt != r_state)   r_to_cnt <= '0;
    else if (TO_EN && w_result)        r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign total_miss = r_total_miss;
  assign combo      = r_combo;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle-level behavioural model.
module tb_game_flow_ctrl;

  localparam int MAX_MISS = 7;
  localparam int COMBO_W  = 4;
  localparam int TO       = 4;
  localparam int MISS_W   = $clog2(MAX_MISS + 1);
  localparam int COMBO_MAX = (1 << COMBO_W) - 1;

  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_WIN = 3, M_LOSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, key_start, key_back, miss, hit, done;
  logic menu, map, paused, win, lose;
  logic [MISS_W-1:0]  total_miss;
  logic [COMBO_W-1:0] combo;

  game_flow_ctrl #(
    .MAX_MISS       (MAX_MISS),
    .COMBO_W        (COMBO_W),
    .RESULT_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_start  (key_start),
    .key_back   (key_back),
    .miss       (miss),
    .hit        (hit),
    .done       (done),
    .menu       (menu),
    .map        (map),
    .paused     (paused),
    .win        (win),
    .lose       (lose),
    .total_miss (total_miss),
    .combo      (combo)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: screen, counts, previous key levels, cycle of result entry.
  int m_state = M_IDLE;
  int m_miss  = 0;
  int m_combo = 0;
  int m_entry = 0;
  int cyc     = 0;
  bit m_ks_q  = 1'b1;
  bit m_kb_q  = 1'b1;
  bit pause_en;

  task automatic model_step();
    bit s_e, b_e;
    s_e = key_start && !m_ks_q;
    b_e = key_back && !m_kb_q;
    cyc++;
    if (!resetn) begin
      m_state = M_IDLE; m_miss = 0; m_combo = 0;
      m_ks_q = 1'b1; m_kb_q = 1'b1;
      return;
    end
    m_ks_q = key_start;
    m_kb_q = key_back;
    case (m_state)
      M_IDLE: if (s_e && !b_e) begin
        m_state = M_PLAY; m_miss = 0; m_combo = 0;
      end
      M_PLAY: begin
        if (b_e) m_state = pause_en ? M_PAUSE : M_IDLE;
        else if (done) begin
          m_state = M_WIN; m_entry = cyc;
        end else if (miss) begin
          m_miss++; m_combo = 0;
          if (m_miss == MAX_MISS) begin
            m_state = M_LOSE; m_entry = cyc;
          end
        end else if (hit && m_combo < COMBO_MAX) m_combo++;
      end
      M_PAUSE: begin
        if (b_e) m_state = M_IDLE;
        else if (s_e) m_state = M_PLAY;
      end
      default: begin
        if (b_e || (TO > 0 && cyc - m_entry == TO)) m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("menu",       32'(menu),       32'(m_state == M_IDLE));
    check("map",        32'(map),        32'(m_state == M_PLAY || m_state == M_PAUSE));
    check("paused",     32'(paused),     32'(m_state == M_PAUSE));
    check("win",        32'(win),        32'(m_state == M_WIN));
    check("lose",       32'(lose),       32'(m_state == M_LOSE));
    check("total_miss", 32'(total_miss), m_miss);
    check("combo",      32'(combo),      m_combo);
  endtask

  task automatic step(input bit s, input bit b, input bit m, input bit h, input bit d);
    key_start = s; key_back = b; miss = m; hit = h; done = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic start_play();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef GAME_PAUSE_EN
    pause_en = 1'b1;
`else
    pause_en = 1'b0;
`endif
    resetn = 1'b0;
    key_start = 0; key_back = 0; miss = 0; hit = 0; done = 0;
    #2;
    idle(2);
    check("rst_menu", 32'(menu), 1);
    check("rst_map",  32'(map), 0);
    check("rst_miss", 32'(total_miss), 0);
    check("rst_combo", 32'(combo), 0);
    resetn = 1'b1;
    idle(2);

    // Full loss, then auto-return exactly TO cycles after entering LOSE.
    start_play();
    for (int i = 1; i <= MAX_MISS; i++) begin
      step(0, 0, 1, 0, 0);
      if (i < MAX_MISS) check("loss_cnt", 32'(total_miss), i);
    end
    check("loss_lose", 32'(lose), 1);
    check("loss_total", 32'(total_miss), MAX_MISS);
    idle(TO - 1);
    check("loss_hold", 32'(lose), 1);
    idle(1);
    check("loss_timeout_menu", 32'(menu), 1);

    // Win with combo, left via back press before the timeout.
    start_play();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    check("combo5", 32'(combo), 5);
    step(0, 0, 1, 0, 0);
    check("combo0", 32'(combo), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    check("combo3", 32'(combo), 3);
    step(0, 0, 0, 0, 1);
    idle(1);
    check("win_win", 32'(win), 1);
    check("win_miss", 32'(total_miss), 1);
    check("win_combo", 32'(combo), 3);
    step(0, 1, 0, 0, 0);
    check("win_back_menu", 32'(menu), 1);
    idle(1);

    // done and miss together at MAX_MISS-1 misses.
    start_play();
    for (int i = 0; i < MAX_MISS - 1; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check("donemiss_win", 32'(win), 1);
    check("donemiss_total", 32'(total_miss), MAX_MISS - 1);
    idle(TO + 1);

    // Back press in PLAY.
    start_play();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    if (pause_en) begin
      check("pause_paused", 32'(paused), 1);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      check("pause_miss_held", 32'(total_miss), 2);
      step(1, 0, 0, 0, 0);
      check("resume_map", 32'(map), 1);
      check("resume_miss", 32'(total_miss), 2);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("pause_again", 32'(paused), 1);
      step(1, 1, 0, 0, 0);
      check("both_keys_menu", 32'(menu), 1);
    end else begin
      check("back_menu", 32'(menu), 1);
      check("back_paused", 32'(paused), 0);
    end
    idle(1);

    // Start key held through reset release produces no press.
    resetn = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    check("held_menu", 32'(menu), 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("repress_map", 32'(map), 1);
    step(0, 0, 0, 0, 0);

    // Combo saturates, then reset mid-PLAY discards everything.
    for (int i = 0; i < COMBO_MAX + 5; i++) step(0, 0, 0, 1, 0);
    check("combo_sat", 32'(combo), COMBO_MAX);
    step(0, 0, 1, 1, 0);
    check("hitmiss_combo", 32'(combo), 0);
    resetn = 1'b0;
    step(0, 0, 0, 0, 0);
    check("midrst_menu", 32'(menu), 1);
    check("midrst_miss", 32'(total_miss), 0);
    resetn = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit s, b;
      resetn = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 5) == 0) ? !key_start : key_start;
      b = ($urandom_range(0, 9) == 0) ? !key_back  : key_back;
      step(s, b, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter MAX_MISS, default 7, misses that end play with a loss (1..255).
REQ-002 SHALL have parameter COMBO_W, default 8, width of the combo counter.
REQ-003 SHALL have parameter RESULT_TIMEOUT, default 0, cycles before a result screen auto-returns to IDLE; 0 disables auto-return.
REQ-004 SHALL derive localparam MISS_W = $clog2(MAX_MISS+1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port key_start, input, 1, level-active start/resume key.
REQ-008 SHALL have port key_back, input, 1, level-active back/pause key.
REQ-009 SHALL have ports miss, hit and done, each input, 1, single-cycle pulses from the datapath.
REQ-010 SHALL have ports menu, map, paused, win and lose, each output, 1, screen selects.
REQ-011 SHALL have port total_miss, output, MISS_W, the current miss count.
REQ-012 SHALL have port combo, output, COMBO_W, the current consecutive-hit count.

Function
REQ-013 SHALL act on key rising edges only: edge = key & ~key_q, with key_q registered each cycle.
REQ-014 SHALL implement states IDLE, PLAY, PAUSE, WIN and LOSE as Moore outputs decoded from the state register; an output changes on the clock edge that samples its trigger.
REQ-015 SHALL drive the screen selects as follows: IDLE menu=1; PLAY map=1; PAUSE map=1 and paused=1; WIN win=1; LOSE lose=1; every other select 0.
REQ-016 SHALL leave IDLE only on a key_start edge, going to PLAY and clearing total_miss and combo.
REQ-017 SHALL apply PLAY priority, highest first: key_back edge, then done (to WIN), then miss, then hit.
REQ-018 SHALL, on miss in PLAY, increment total_miss and clear combo; the miss that makes total_miss equal MAX_MISS goes to LOSE.
REQ-019 SHALL, on hit without miss in PLAY, increment combo, saturating at all-ones; hit and miss together leaves combo cleared.
REQ-020 SHALL, when done and miss coincide in PLAY, go to WIN and leave total_miss unchanged.
REQ-021 SHALL ignore miss, hit and done in every state except PLAY.
REQ-022 SHALL, in WIN and LOSE, hold total_miss and combo at their final values; a key_back edge returns to IDLE.
REQ-023 SHALL, when RESULT_TIMEOUT>0, return WIN/LOSE to IDLE after RESULT_TIMEOUT cycles in the state; a key_back edge returns immediately.
REQ-024 SHALL clear the timeout counter on every entry to WIN or LOSE.
REQ-025 SHALL, when key_start and key_back edges occur in the same cycle, apply only key_back.

Reset
REQ-026 SHALL, while resetn=0 at a clock edge, set state IDLE, total_miss 0, combo 0 and timeout counter 0.
REQ-027 SHALL, during reset, drive menu=1 and map, paused, win and lose 0.
REQ-028 SHALL reset key_q registers to 1, so a key held through reset release produces no edge.
REQ-029 SHALL abandon any state on reset mid-operation, with no carry-over of counts.

Configuration
REQ-030 SHALL, with macro GAME_PAUSE_EN defined, send a key_back edge in PLAY to PAUSE.
REQ-031 SHALL, with GAME_PAUSE_EN defined, resume from PAUSE to PLAY on a key_start edge with counters kept, and go to IDLE on a key_back edge.
REQ-032 SHALL, without GAME_PAUSE_EN, omit the PAUSE state, tie paused to 0 and send a key_back edge in PLAY directly to IDLE.

Structure
REQ-033 SHALL place the state enum and encoding, and the default constants for MAX_MISS, COMBO_W and RESULT_TIMEOUT, in shared package game_pkg.
REQ-034 SHALL implement edge detection as sub-module key_edge_detect (ports clk, resetn, key, rise), instantiated once per key.

Verification
REQ-035 SHALL cover a full loss: MAX_MISS=7; key_start pulse, 7 miss pulses -> total_miss counts 1..6 in PLAY; 7th miss gives lose=1 next cycle with total_miss=7.
REQ-036 SHALL cover a win with combo: 5 hit, 1 miss, 3 hit, then done -> combo 5, 0, then 3; win=1, total_miss=1, combo=3 held.
REQ-037 SHALL cover simultaneous events: done+miss in the same cycle at total_miss=6 -> WIN with total_miss=6; key_start+key_back edges together in PAUSE -> IDLE.
REQ-038 SHALL cover held keys: key_start held high through reset release, then for 10 cycles -> state stays IDLE; release and re-press -> PLAY.
REQ-039 SHALL cover pause, with GAME_PAUSE_EN: key_back edge in PLAY -> paused=1; miss pulses ignored; key_start edge -> PLAY, counts unchanged. Without the macro: key_back edge -> menu=1.
REQ-040 SHALL cover timeout: RESULT_TIMEOUT=4; lose entered -> menu=1 exactly 4 cycles later; resetn=0 mid-PLAY -> next cycle menu=1 and total_miss=0.
